reg_file_32: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Provides one synchronous write port and two asynchronous (combinational) read ports, A and B, which feed the ALU operands.
- Register 0 is the MIPS $zero register: it always reads 0.

---
 rtl/reg_file_32_pkg.sv | 12 +
 rtl/reg_file_read_mux.sv | 17 +
 rtl/reg_file_32.sv | 41 ++++
 tb/tb_reg_file_32.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_32_pkg.sv
// Shared constants and types for the 32 x 32-bit MIPS register file.
package reg_file_32_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned ADDR_WIDTH = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned ZERO_REG   = 0;

   typedef logic [DATA_WIDTH-1:0] word_t;
   typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_read_mux.sv
// 32:1 word-wide combinational read mux; index 0 always returns zero ($zero).
module reg_file_read_mux
   import reg_file_32_pkg::*;
(
   input  word_t    regs [NUM_REGS],
   input  reg_idx_t sel,
   output word_t    data
);

   always_comb begin
      data = '0;
      if (sel != reg_idx_t'(ZERO_REG)) begin
         data = regs[sel];
      end
   end

endmodule

// File: rtl/reg_file_32.sv
// Register file with one synchronous write port and two combinational read ports.
module reg_file_32
   import reg_file_32_pkg::*;
(
   input  logic     clock,
   input  logic     reset_n,
   input  logic     writeEnable,
   input  reg_idx_t writeSel,
   input  word_t    writeData,
   input  reg_idx_t readSelA,
   input  reg_idx_t readSelB,
   output word_t    readRegA,
   output word_t    readRegB
);

   word_t regs [NUM_REGS];

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs[i] <= '0;
         end
      end else if (writeEnable && (writeSel != reg_idx_t'(ZERO_REG))) begin
         regs[writeSel] <= writeData;
      end
   end

   reg_file_read_mux uMuxA (
      .regs (regs),
      .sel  (readSelA),
      .data (readRegA)
   );

   reg_file_read_mux uMuxB (
      .regs (regs),
      .sel  (readSelB),
      .data (readRegB)
   );

endmodule

// File: tb/tb_reg_file_32.sv
// Directed self-checking bench for reg_file_32.
module tb_reg_file_32;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        writeEnable;
   logic [4:0]  writeSel;
   logic [31:0] writeData;
   logic [4:0]  readSelA;
   logic [4:0]  readSelB;
   logic [31:0] readRegA;
   logic [31:0] readRegB;

   int nTotal = 0;
   int nBad   = 0;

   reg_file_32 dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .writeEnable (writeEnable),
      .writeSel    (writeSel),
      .writeData   (writeData),
      .readSelA    (readSelA),
      .readSelB    (readSelB),
      .readRegA    (readRegA),
      .readRegB    (readRegB)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTotal++;
      if (obs !== exp) begin
         nBad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pattern(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, b, b, b};
   endfunction

   initial begin
      reset_n     = 1'b0;
      writeEnable = 1'b1;
      writeSel    = 5'd12;
      writeData   = 32'hFFFF_FFFF;
      readSelA    = 5'd1;
      readSelB    = 5'd12;

      // Writes attempted across several edges while in reset
      repeat (3) @(posedge clock);
      #1;
      chk("rst_r1", readRegA, 32'h0);
      chk("rst_r12", readRegB, 32'h0);
      readSelA = 5'd31;
      #1;
      chk("rst_r31", readRegA, 32'h0);

      // Basic write / read
      @(negedge clock);
      reset_n     = 1'b1;
      writeEnable = 1'b1;
      writeSel    = 5'd12;
      writeData   = 32'hAAAA_AAAA;
      readSelA    = 5'd12;
      readSelB    = 5'd13;
      @(posedge clock);
      #1;
      chk("wr12_a", readRegA, 32'hAAAA_AAAA);
      chk("rd13_b", readRegB, 32'h0);

      // Write-enable gating
      @(negedge clock);
      writeEnable = 1'b0;
      writeSel    = 5'd13;
      writeData   = 32'hBBBB_BBBB;
      repeat (2) @(posedge clock);
      #1;
      chk("we0_b13", readRegB, 32'h0);
      @(negedge clock);
      writeEnable = 1'b1;
      @(posedge clock);
      #1;
      chk("we1_b13", readRegB, 32'hBBBB_BBBB);
      @(negedge clock);
      writeEnable = 1'b0;

      // Read selects change with no clock edge in between
      #1;
      readSelA = 5'd14;
      readSelB = 5'd15;
      #1;
      chk("async_a14", readRegA, 32'h0);
      chk("async_b15", readRegB, 32'h0);
      readSelA = 5'd12;
      readSelB = 5'd13;
      #1;
      chk("async_a12", readRegA, 32'hAAAA_AAAA);
      chk("async_b13", readRegB, 32'hBBBB_BBBB);

      // Same index on both ports
      readSelB = 5'd12;
      #1;
      chk("same_b12", readRegB, 32'hAAAA_AAAA);

      // Write to $zero is discarded
      @(negedge clock);
      writeEnable = 1'b1;
      writeSel    = 5'd0;
      writeData   = 32'h1234_5678;
      readSelA    = 5'd0;
      readSelB    = 5'd0;
      @(posedge clock);
      #1;
      chk("zero_a", readRegA, 32'h0);
      chk("zero_b", readRegB, 32'h0);

      // No write-to-read bypass
      @(negedge clock);
      writeSel  = 5'd12;
      writeData = 32'h5555_5555;
      readSelA  = 5'd12;
      #1;
      chk("nobyp_old", readRegA, 32'hAAAA_AAAA);
      @(posedge clock);
      #1;
      chk("nobyp_new", readRegA, 32'h5555_5555);

      // Full sweep
      for (int i = 1; i < 32; i++) begin
         @(negedge clock);
         writeEnable = 1'b1;
         writeSel    = 5'(i);
         writeData   = pattern(i);
         @(posedge clock);
      end
      @(negedge clock);
      writeEnable = 1'b0;
      for (int i = 1; i < 32; i++) begin
         readSelA = 5'(i);
         readSelB = 5'(32 - i);
         #1;
         chk($sformatf("sweep_a%0d", i), readRegA, pattern(i));
         chk($sformatf("sweep_b%0d", 32 - i), readRegB, pattern(32 - i));
      end

      // Asynchronous reset pulse between edges
      @(negedge clock);
      #1;
      readSelA = 5'd7;
      readSelB = 5'd31;
      #1;
      chk("pre_rst_a7", readRegA, pattern(7));
      reset_n = 1'b0;
      #1;
      chk("arst_a7", readRegA, 32'h0);
      chk("arst_b31", readRegB, 32'h0);
      reset_n = 1'b1;
      for (int i = 1; i < 32; i++) begin
         readSelA = 5'(i);
         #1;
         chk($sformatf("post_rst_a%0d", i), readRegA, 32'h0);
      end

      // Reset asserted together with an enabled write edge: reset wins
      @(negedge clock);
      writeEnable = 1'b1;
      writeSel    = 5'd20;
      writeData   = 32'hDEAD_BEEF;
      readSelA    = 5'd20;
      @(posedge clock);
      reset_n = 1'b0;
      #1;
      chk("rst_wins_a20", readRegA, 32'h0);
      @(negedge clock);
      writeEnable = 1'b0;
      reset_n     = 1'b1;
      @(posedge clock);
      #1;
      chk("gated_a20", readRegA, 32'h0);

      $display("test done: total=%0d bad=%0d", nTotal, nBad);
      $finish;
   end

endmodule
